// File: rtl/muldiv_seq.sv
// muldiv_seq -- iterative multiply/divide sequencer owning the HI/LO registers.
//
// Runs MULT, MULTU, DIV and DIVU on one shared shift/add-subtract datapath,
// one iteration per clock (WIDTH iterations), followed by a single
// sign-fix/writeback cycle. busy stays high from the start edge up to the
// writeback edge. The hazard unit uses busy to hold off HI/LO accesses and
// new operations.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   start  in   launch an operation (accepted only when idle)
//   op     in   2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU
//   a, b   in   rs / rt operands, latched on the start edge
//   hi_we  in   MTHI write enable (idle only; start takes priority)
//   lo_we  in   MTLO write enable (idle only; start takes priority)
//   wd     in   MTHI/MTLO write data
//   abort  in   drop the in-flight operation without touching HI/LO
//   busy   out  operation in progress
//   done   out  one-cycle pulse, HI/LO were just written by an operation
//   hi, lo out  architectural HI/LO registers
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;      // negate product / quotient
    logic             neg_rem_q, neg_rem_d;      // remainder follows dividend sign
    logic             div_zero_q, div_zero_d;
    // Multiply: acc = upper product half, shreg = multiplier then lower half,
    //           opnd = multiplicand.
    // Divide:   acc = partial remainder, shreg = dividend then quotient,
    //           opnd = divisor.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    // Operand preparation (signed ops use magnitudes).
    logic             signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // Iteration datapath.
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             q_bit;

    // Writeback values.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;

        // Shift-add step: conditionally add multiplicand to the upper half,
        // then shift the whole 2*WIDTH product right by one.
        add_sum   = {1'b0, acc_q} + (shreg_q[0] ? {1'b0, opnd_q} : '0);

        // Restoring divide step: shift the next dividend bit into the
        // remainder and trial-subtract. The borrow bit is the inverse of the
        // quotient bit, and on success the difference always fits in WIDTH.
        rem_shift = {acc_q, shreg_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opnd_q};
        q_bit     = ~rem_diff[WIDTH];

        prod_fix  = neg_res_q ? -{acc_q, shreg_q} : {acc_q, shreg_q};
        // With a zero divisor every trial subtract succeeds, so the quotient
        // ends all ones and the remainder ends equal to |a|; restoring the
        // dividend sign on it gives back the original a.
        quot_fix  = (neg_res_q && !div_zero_q) ? -shreg_q : shreg_q;
        rem_fix   = neg_rem_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        acc_d      = acc_q;
        shreg_d    = shreg_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d   = op[1];
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = op[1] && (b == '0);
                    acc_d      = '0;
                    shreg_d    = op[1] ? a_mag : b_mag;
                    opnd_d     = op[1] ? b_mag : a_mag;
                    cnt_d      = CW'(WIDTH);
                    state_d    = S_RUN;
                end else begin
                    if (hi_we) hi_d = wd;
                    if (lo_we) lo_d = wd;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_d   = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                        shreg_d = {shreg_q[WIDTH-2:0], q_bit};
                    end else begin
                        acc_d   = add_sum[WIDTH:1];
                        shreg_d = {add_sum[0], shreg_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!abort) begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            acc_q      <= '0;
            shreg_q    <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            acc_q      <= acc_d;
            shreg_q    <= shreg_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq -- self-checking bench for muldiv_seq (WIDTH=32).
// Directed corner cases plus randomized operations against a reference model
// that uses plain 64-bit arithmetic on the architectural definitions.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        hi_we, lo_we;
    logic [31:0] wd;
    logic        abort;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset_n),
        .start (start),
        .op    (op_i),
        .a     (a_i),
        .b     (b_i),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: MIPS HI/LO results from plain arithmetic.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb, q, r;
        logic [63:0] p, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = '0;
        l = '0;
        case (op)
            2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
            2'b10: begin
                if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
                else begin
                    q = sa / sb; r = sa % sb;   // truncating: remainder has dividend sign
                    qv = q; rv = r; h = rv[31:0]; l = qv[31:0];
                end
            end
            default: begin
                if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
                else begin h = a % b; l = a / b; end
            end
        endcase
    endtask

    // Launch one operation and check latency, done pulse and HI/LO.
    // lo_we_s / abort_s: assert lo_we / abort together with start.
    // poke: pulse start/hi_we/lo_we mid-operation (must be ignored).
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_h, input logic [31:0] exp_l,
                          input bit lo_we_s, input bit abort_s, input bit poke);
        logic [31:0] hi_pre, lo_pre;
        int cycles;
        bit saw_done;
        @(negedge clk);
        hi_pre = hi; lo_pre = lo;
        start = 1'b1; op_i = op; a_i = a; b_i = b;
        lo_we = lo_we_s; wd = 32'h55555555; abort = abort_s;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0; abort = 1'b0;
        op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;   // operands may change after launch
        check({tag, " hi_after_start"}, hi, hi_pre);
        check({tag, " lo_after_start"}, lo, lo_pre);
        cycles = 0;
        saw_done = 1'b0;
        while (busy && cycles < 100) begin
            cycles++;
            if (done) saw_done = 1'b1;
            if (poke && cycles == 5) begin
                start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wd = 32'hDEADBEEF;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check({tag, " busy_cycles"}, cycles, 33);
        check({tag, " done_early"}, 32'(saw_done), 0);
        check({tag, " done"}, 32'(done), 1);
        check({tag, " hi"}, hi, exp_h);
        check({tag, " lo"}, lo, exp_l);
        $display("op %0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d (%s)", op, a, b, hi, lo, cycles, tag);
        @(negedge clk);
        check({tag, " done_clear"}, 32'(done), 0);
    endtask

    // Launch then abort when the op has been busy for at_cycle cycles.
    task automatic abort_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int at_cycle);
        logic [31:0] hi_pre, lo_pre;
        bit saw_done;
        @(negedge clk);
        hi_pre = hi; lo_pre = lo;
        start = 1'b1; op_i = op; a_i = a; b_i = b;
        @(negedge clk);
        start = 1'b0;
        saw_done = 1'b0;
        for (int i = 1; i < at_cycle; i++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check({tag, " busy"}, 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check({tag, " done_never"}, 32'(saw_done), 0);
        check({tag, " hi"}, hi, hi_pre);
        check({tag, " lo"}, lo, lo_pre);
        $display("abort op %0d at cycle %0d -> hi=%h lo=%h busy=%0d", op, at_cycle, hi, lo, busy);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb, eh, el;

        reset_n = 1'b0; start = 1'b0; op_i = '0; a_i = '0; b_i = '0;
        hi_we = 1'b0; lo_we = 1'b0; wd = '0; abort = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        reset_n = 1'b1;

        // MTHI + MTLO in the same cycle.
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'hCAFEF00D;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi_mtlo hi", hi, 32'hCAFEF00D);
        check("mthi_mtlo lo", lo, 32'hCAFEF00D);
        $display("mthi/mtlo wd=cafef00d -> hi=%h lo=%h", hi, lo);

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 0, 0);
        run_op("mult_neg",  2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0, 0);
        run_op("mult_min",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 0, 0);
        run_op("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 0);
        run_op("divu_zero", 2'b11, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 0, 0, 0);
        run_op("div_zero",  2'b10, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 0, 0, 0);
        run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 0, 0);
        run_op("poke_busy", 2'b01, 32'd1000,     32'd3000,     32'h00000000, 32'd3000000,  0, 0, 1);

        // Abort in RUN and in FIX, with a known HI from MTHI.
        @(negedge clk);
        hi_we = 1'b1; wd = 32'h11111111;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi hi", hi, 32'h11111111);
        abort_op("abort_run", 2'b01, 32'd5, 32'd6, 10);
        abort_op("abort_fix", 2'b01, 32'd5, 32'd6, 33);

        // start wins over lo_we; abort alongside start in IDLE is ignored.
        run_op("start_lo_we", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1, 0, 0);
        run_op("start_abort", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0, 1, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h80000000;
                2: rb = 32'hFFFFFFFF;
                3: rb = rb >> $urandom_range(1, 31);
                default: ;
            endcase
            model(rop, ra, rb, eh, el);
            run_op($sformatf("rand%0d", i), rop, ra, rb, eh, el, 0, 0, 0);
        end

        // Asynchronous reset mid-operation.
        @(negedge clk);
        start = 1'b1; op_i = 2'b01; a_i = 32'd9; b_i = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst busy", 32'(busy), 0);
        check("async_rst done", 32'(done), 0);
        check("async_rst hi", hi, 0);
        check("async_rst lo", lo, 0);
        $display("async reset mid-run -> busy=%0d hi=%h lo=%h", busy, hi, lo);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst busy", 32'(busy), 0);
        check("post_rst lo", lo, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multiply/divide sequencer for the pipelined MIPS core. It owns the HI/LO architectural registers and sequences a shared shift/add-subtract datapath for MULT, MULTU, DIV and DIVU. It is started from the EX stage and exposes busy to the hazard unit, which stalls MFHI/MFLO, MTHI/MTLO and any new mult/div while busy is high. It also provides an abort path for pipeline flushes.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  launch operation; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wd  input  WIDTH  MTHI/MTLO write data
abort  input  1  cancel in-flight operation (flush/exception)
busy  output  1  operation in progress
done  output  1  one-cycle pulse: HI/LO just updated by an operation
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset low, async): state=IDLE, busy=0, done=0, hi=0, lo=0, internal counter/accumulators cleared. Reset mid-operation discards it with no HI/LO update.
- States: IDLE, RUN, FIX. busy = (state != IDLE), decoded from registered state.
- IDLE:
  - start=1 at edge E0: latch op, |a|, |b| (magnitudes for signed ops, raw values for unsigned ops), result signs and the b==0 flag; load counter=WIDTH; go to RUN.
  - Otherwise hi_we loads hi<=wd and lo_we loads lo<=wd; both may be asserted in the same cycle.
  - start has priority: in a cycle with start=1, hi_we/lo_we are ignored.
- RUN: one iteration per edge, E1..E32 for WIDTH=32.
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - At the edge where counter reaches 0, go to FIX.
- FIX, edge E33:
  - Apply sign correction and write HI/LO. Multiply: {hi,lo}=product. Divide: lo=quotient, hi=remainder.
  - Set done=1 and go to IDLE. done clears at the next edge.
  - busy is high for exactly WIDTH+1 cycles (E0..E33). New HI/LO values and done appear together in the cycle after E33.
- Sign rules for MULT/DIV:
  - Product and quotient are negated (two's complement, full width) iff the sign bits of a and b differ.
  - The remainder takes the sign of the dividend.
- Divide by zero (any division op with b==0): hi=a, lo={WIDTH{1}}, no sign correction. Full latency still applies.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap, no trap).
- While busy:
  - start, hi_we and lo_we are ignored; the hazard unit prevents them, but the block must be safe if they occur.
  - op, a and b may change freely after E0.
- abort:
  - When asserted in RUN or FIX, the state returns to IDLE at the next edge. HI/LO are unchanged and done stays 0.
  - abort in the FIX cycle suppresses the write.
  - abort in IDLE has no effect; a simultaneous start in IDLE is still accepted.

Test Plan:
- Reset low mid-RUN -> busy=0, done=0, hi=lo=0 immediately, without waiting for a clock edge; after release, busy stays 0 until start.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001 with a single-cycle done pulse.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> hi=7, lo=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- With hi=0x11111111 from a prior MTHI, start MULTU 5*6, assert abort in RUN cycle 10 -> busy=0 next cycle, hi=0x11111111 unchanged, done never asserted.
- IDLE: hi_we=1, lo_we=1, wd=0xCAFEF00D -> both registers updated next edge. While busy: hi_we and start pulses are ignored and the result is unaffected. start together with lo_we in IDLE -> lo_we is dropped and the op runs.
